// File: rtl/uart_feeder_pkg.sv
// Shared types and UART register map for the UART transmit feeder.
package uart_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_POLL,
    ST_SAMPLE
  } FeederState;

  localparam logic [2:0] UART_CTRL_ADDR = 3'b000;
  localparam logic [2:0] UART_TX_ADDR   = 3'b010;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART feeder; a pop frees a slot for a push in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered bytes into a UART: write TX register, then poll control until not busy.
// Define UART_TX_FEEDER_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_feeder
  import uart_feeder_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int BUSY_BIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       cs,
  output logic       wr,
  output logic [2:0] addr,
  output logic [7:0] tx_data,
  output logic       rd_strobe,
  input  logic       rd_busy,
  input  logic [7:0] rd_data,
  output logic       idle
);

  FeederState state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ready_en_q, ready_en_d;
  logic       buf_push;
  logic       buf_pop;
  logic       buf_full;
  logic       buf_empty;
  logic [7:0] buf_data;
  logic       unused_rd;

  assign unused_rd = ^rd_data;
  assign buf_push  = in_valid & in_ready;

`ifdef UART_TX_FEEDER_FIFO_EN
  uart_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (in_data),
    .rdata (buf_data),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign in_ready = ready_en_q & (~buf_full | buf_pop);
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       unused_depth;

  assign unused_depth = (DEPTH > 0);

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (buf_pop) hold_valid_d = 1'b0;
    if (buf_push) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign buf_full  = hold_valid_q;
  assign buf_empty = ~hold_valid_q;
  assign buf_data  = hold_q;
  assign in_ready  = ready_en_q & ~buf_full;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    ready_en_d = 1'b1;
    buf_pop    = 1'b0;
    cs         = 1'b1;
    wr         = 1'b1;
    rd_strobe  = 1'b1;
    addr       = UART_CTRL_ADDR;
    case (state_q)
      ST_IDLE: begin
        if (!buf_empty) begin
          buf_pop   = 1'b1;
          tx_data_d = buf_data;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cs      = 1'b0;
        addr    = UART_TX_ADDR;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cs      = 1'b0;
        addr    = UART_TX_ADDR;
        wr      = 1'b0;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        cs        = 1'b0;
        rd_strobe = 1'b0;
        state_d   = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cs = 1'b0;
        // busy flag is only meaningful once the UART read has completed
        if (!rd_busy) state_d = rd_data[BUSY_BIT] ? ST_POLL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign tx_data = tx_data_q;
  assign idle    = buf_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a behavioural UART responder.
// Expectations adapt to UART_TX_FEEDER_FIFO_EN (FIFO) versus the holding-register build.
module tb_uart_tx_feeder;

`ifdef UART_TX_FEEDER_FIFO_EN
  localparam int CAP  = 8;
  localparam int GAP2 = 1;
  localparam int NQ   = 4;
`else
  localparam int CAP  = 1;
  localparam int GAP2 = 2;
  localparam int NQ   = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cs;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] tx_data;
  logic       rd_strobe;
  logic       rd_busy;
  logic [7:0] rd_data;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int strobe_cnt = 0;
  int wr_bad = 0;
  int busy_cyc = 0;
  int cs_hi_busy = 0;
  int hold_cnt = 0;
  int busy_left = 0;
  int last_acc = 0;
  logic [7:0] wq [$];

  always #5 clock = ~clock;

  uart_tx_feeder #(
    .DEPTH    (8),
    .BUSY_BIT (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cs        (cs),
    .wr        (wr),
    .addr      (addr),
    .tx_data   (tx_data),
    .rd_strobe (rd_strobe),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .idle      (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic respond();
    rd_busy = 1'b0;
    if (busy_left > 0) begin
      rd_data = 8'h02;
      busy_left--;
    end else begin
      rd_data = 8'h00;
    end
  endtask

  // observe bus at negedge, then drive the UART response for the next edge
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (!wr) begin
      wr_cnt++;
      if (cs || addr !== 3'b010) wr_bad++;
      wq.push_back(tx_data);
    end
    if (rd_busy) begin
      busy_cyc++;
      if (cs) cs_hi_busy++;
    end
    if (!rd_strobe) begin
      strobe_cnt++;
      if (hold_cnt > 0) begin
        rd_busy = 1'b1;
        rd_data = 8'h02;
      end else begin
        respond();
      end
    end else if (rd_busy) begin
      hold_cnt--;
      if (hold_cnt <= 0) respond();
    end
  endtask

  task automatic clr();
    wr_cnt     = 0;
    strobe_cnt = 0;
    busy_cyc   = 0;
    cs_hi_busy = 0;
    wq.delete();
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("push_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle && n < 400) begin
      tick();
      n++;
    end
    check("idle_wait", {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    while (strobe_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    check("strobe_wait", {31'd0, (strobe_cnt > 0)}, 32'd1);
  endtask

  task automatic check_q(input string tag, input logic [7:0] e);
    if (wq.size() == 0) check(tag, 32'hdead, {24'd0, e});
    else check(tag, {24'd0, wq.pop_front()}, {24'd0, e});
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cs"},   {31'd0, cs},        32'd1);
    check({pfx, "_wr"},   {31'd0, wr},        32'd1);
    check({pfx, "_rds"},  {31'd0, rd_strobe}, 32'd1);
    check({pfx, "_addr"}, {29'd0, addr},      32'd0);
    check({pfx, "_rdy"},  {31'd0, in_ready},  32'd0);
    check({pfx, "_idle"}, {31'd0, idle},      32'd1);
    check({pfx, "_txd"},  {24'd0, tx_data},   32'd0);
  endtask

  initial begin
    int a;
    int n;
    int base;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_busy  = 1'b0;
    rd_data  = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rdy_pre", {31'd0, in_ready}, 32'd0);
    tick();
    check("rdy_post", {31'd0, in_ready}, 32'd1);

    // single byte, UART never busy: fixed five-cycle turnaround
    clr();
    push(8'h4F);
    repeat (4) tick();
    check("t1_idle4", {31'd0, idle}, 32'd0);
    tick();
    check("t1_idle5", {31'd0, idle}, 32'd1);
    check("t1_wrs", wr_cnt, 32'd1);
    check("t1_strb", strobe_cnt, 32'd1);
    check_q("t1_byte", 8'h4F);

    // busy reported on three samples
    clr();
    busy_left = 3;
    push(8'h41);
    wait_idle();
    check("t2_strb", strobe_cnt, 32'd4);
    check("t2_wrs", wr_cnt, 32'd1);
    check_q("t2_byte", 8'h41);

    // rd_busy held across four SAMPLE cycles with busy bit set meanwhile
    clr();
    hold_cnt = 4;
    push(8'h5A);
    wait_idle();
    check("t3_busyc", busy_cyc, 32'd4);
    check("t3_cshi", cs_hi_busy, 32'd0);
    check("t3_strb", strobe_cnt, 32'd1);
    check("t3_wrs", wr_cnt, 32'd1);
    check_q("t3_byte", 8'h5A);

    // fill the buffer while the UART stays busy
    clr();
    busy_left = 1000;
    push(8'hA0);
    wait_strobe();
    for (int i = 0; i < CAP; i++) push(8'hB0 + 8'(i));
    check("t4_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    repeat (6) tick();
    check("t4_held", {31'd0, in_ready}, 32'd0);
    busy_left = 0;
    push(8'hC0);
    wait_idle();
    check("t4_wrs", wr_cnt, CAP + 2);
    check_q("t4_b0", 8'hA0);
    for (int i = 0; i < CAP; i++) check_q("t4_bn", 8'hB0 + 8'(i));
    check_q("t4_last", 8'hC0);

    // acceptance spacing of two bytes offered from idle
    clr();
    push(8'h61);
    a = last_acc;
    push(8'h62);
    check("t5_gap", last_acc - a, GAP2);
    wait_idle();
    check_q("t5_b0", 8'h61);
    check_q("t5_b1", 8'h62);

    // reset while a write is on the bus with bytes still queued
    clr();
    busy_left = 1000;
    push(8'hD0);
    wait_strobe();
    for (int i = 0; i < NQ; i++) push(8'hD1 + 8'(i));
    busy_left = 0;
    n = 0;
    while (wr_cnt < 2 && n < 200) begin
      tick();
      n++;
    end
    check("t6_inwr", {31'd0, wr}, 32'd0);
    reset     = 1'b0;
    rd_busy   = 1'b0;
    rd_data   = 8'h00;
    hold_cnt  = 0;
    #1;
    check_reset_outputs("t6");
    repeat (2) tick();
    reset = 1'b1;
    base  = wr_cnt;
    repeat (30) tick();
    check("t6_nowr", wr_cnt, base);
    check("t6_idle", {31'd0, idle}, 32'd1);
    check("t6_rdy", {31'd0, in_ready}, 32'd1);

    check("wr_bus", wr_bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
